// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Receives raw PS/2 keyboard clock/data, frames 11-bit words,
//            checks odd parity and stop bit, tracks E0/F0 prefixes, emits
//            one-cycle key-event strobes and a held-key bitmap for the keys
//            the game uses.
// Ports    : clk_i          system clock, everything on posedge
//            rst_i          synchronous active-low reset
//            keyclk_i       raw PS/2 clock (asynchronous)
//            keyinput_i     raw PS/2 data  (asynchronous)
//            key_code_o     last completed make/break code, prefixes removed
//            key_ext_o      key_code_o was preceded by E0
//            key_release_o  key_code_o was preceded by F0
//            key_valid_o    one-cycle strobe: code/ext/release are new
//            frame_err_o    one-cycle strobe on parity or stop-bit error
//            key_held_o     level bitmap, 1 = key currently down
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        keyclk_i,
  input  logic        keyinput_i,
  output logic [7:0]  key_code_o,
  output logic        key_ext_o,
  output logic        key_release_o,
  output logic        key_valid_o,
  output logic        frame_err_o,
  output logic [13:0] key_held_o
);

  localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t         state_q;
  logic [2:0]     kclk_q;     // [0]=sync1, [1]=sync2, [2]=edge-detect flop
  logic [1:0]     kdat_q;     // [0]=sync1, [1]=sync2
  logic [3:0]     bitcnt_q;
  logic [9:0]     shift_q;    // {stop, parity, data[7:0]} once full
  logic [TW-1:0]  tcnt_q;
  logic           ext_q;
  logic           brk_q;
  logic [7:0]     key_code_q;
  logic           key_ext_q;
  logic           key_release_q;
  logic           key_valid_q;
  logic           frame_err_q;
  logic [13:0]    key_held_q;

  logic           fall;
  logic           din;
  logic [7:0]     rx_byte;
  logic           frame_ok;
  logic           is_drop;
  logic [13:0]    hit_mask;

  assign fall     = ~kclk_q[1] & kclk_q[2];
  assign din      = kdat_q[1];
  assign rx_byte  = shift_q[7:0];
  // Odd parity over data+parity, and a high stop bit.
  assign frame_ok = (^shift_q[8:0]) & shift_q[9];
  assign is_drop  = (rx_byte == 8'h00) || (rx_byte == 8'hAA) || (rx_byte == 8'hE1) ||
                    (rx_byte == 8'hEE) || (rx_byte == 8'hFA) || (rx_byte == 8'hFE) ||
                    (rx_byte == 8'hFF);

  // Held-key bit selected by the pending extended flag plus the code byte.
  always_comb begin
    hit_mask = '0;
    case ({ext_q, rx_byte})
      9'h175:  hit_mask = 14'h0001; // Up
      9'h172:  hit_mask = 14'h0002; // Down
      9'h16B:  hit_mask = 14'h0004; // Left
      9'h174:  hit_mask = 14'h0008; // Right
      9'h01D:  hit_mask = 14'h0010; // W
      9'h01C:  hit_mask = 14'h0020; // A
      9'h01B:  hit_mask = 14'h0040; // S
      9'h023:  hit_mask = 14'h0080; // D
      9'h03B:  hit_mask = 14'h0100; // J
      9'h042:  hit_mask = 14'h0200; // K
      9'h04B:  hit_mask = 14'h0400; // L
      9'h043:  hit_mask = 14'h0800; // I
      9'h05A:  hit_mask = 14'h1000; // Enter
      9'h02D:  hit_mask = 14'h2000; // R
      default: hit_mask = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      kclk_q        <= '0;
      kdat_q        <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      tcnt_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      key_held_q    <= '0;
    end else begin
      kclk_q      <= {kclk_q[1:0], keyclk_i};
      kdat_q      <= {kdat_q[0], keyinput_i};
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      // Inter-edge watchdog: only counts while a frame is in progress.
      if (fall || (state_q != ST_RECV) || (tcnt_q == TO_LAST)) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (fall && !din) begin
            state_q  <= ST_RECV;
            bitcnt_q <= 4'd1;
          end
        end

        ST_RECV: begin
          if (fall) begin
            shift_q  <= {din, shift_q[9:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd10) begin
              state_q <= ST_CHECK;
            end
          end else if (tcnt_q == TO_LAST) begin
            state_q <= ST_IDLE;
          end
        end

        ST_CHECK: begin
          // Edges landing here are not legal PS/2 timing and are ignored.
          state_q <= ST_IDLE;
          if (!frame_ok) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_q <= 1'b1;
          end else if (is_drop) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end else begin
            key_code_q    <= rx_byte;
            key_ext_q     <= ext_q;
            key_release_q <= brk_q;
            key_valid_q   <= 1'b1;
            key_held_q    <= brk_q ? (key_held_q & ~hit_mask) : (key_held_q | hit_mask);
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_code_o    = key_code_q;
  assign key_ext_o     = key_ext_q;
  assign key_release_o = key_release_q;
  assign key_valid_o   = key_valid_q;
  assign frame_err_o   = frame_err_q;
  assign key_held_o    = key_held_q;

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard clock and data lines and decodes each frame into a scan code. Tracks the E0 (extended) and F0 (break) prefixes, emits one-cycle key-event strobes, and keeps a held-key bitmap for every key the game uses: arrow keys for the maze, W/A/S/D and J/K/L/I in battle, Enter to start, R to restart. It sits directly upstream of the game top-level FSM, the maze controller and the battle screen, and replaces their direct use of the raw keyboard pins.

## Interface
- TIMEOUT_CYCLES, 50000: idle `clk` cycles allowed between keyboard clock falling edges mid-frame before the partial frame is discarded.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- keyclk  in  1  raw PS/2 clock, asynchronous.
- keyinput  in  1  raw PS/2 data, asynchronous.
- key_code  out  8  last completed make/break code, without prefixes.
- key_ext  out  1  key_code was preceded by E0.
- key_release  out  1  key_code was preceded by F0 (break).
- key_valid  out  1  one-cycle strobe; key_code, key_ext and key_release are new.
- frame_err  out  1  one-cycle strobe on a parity or stop-bit error.
- key_held  out  14  level bitmap, 1 = key currently down:
  - bits 0-3: Up E0-75, Down E0-72, Left E0-6B, Right E0-74.
  - bits 4-7: W 1D, A 1C, S 1B, D 23.
  - bits 8-11: J 3B, K 42, L 4B, I 43.
  - bits 12-13: Enter 5A, R 2D.

## Operation
- Synchronizer: keyclk and keyinput each pass through 2 flops, plus a third keyclk flop for edge detection. `fall` = sync2 low and sync3 high. Data is sampled from sync2 of keyinput in the `fall` cycle.
- Frame receiver FSM has three states, with a 4-bit bit counter and a 10-bit shift register.
  - IDLE
    - `fall` with data 0 (start bit): go to RECV, bit counter = 1.
    - `fall` with data 1: ignored, stay in IDLE.
  - RECV
    - Each `fall` shifts data in LSB-first (bits 1-8 data, 9 odd parity, 10 stop) and increments the counter.
    - On the `fall` of bit 10: go to CHECK.
  - CHECK (one cycle)
    - Valid frame: XOR of the 8 data bits and the parity bit = 1, and stop = 1. Pass the byte to the decoder and return to IDLE.
    - Invalid frame: pulse frame_err next cycle, clear both prefix flags, return to IDLE.
- Timeout: a counter clears on every `fall` and runs while in RECV. Reaching TIMEOUT_CYCLES-1 forces IDLE with no strobe and no error, and clears the counter.
- Decoder, with pending flags ext_p and brk_p:
  - E0: set ext_p, no strobe.
  - F0: set brk_p, no strobe.
  - 00, AA, E1, EE, FA, FE, FF: drop silently, clear both flags.
  - Any other byte:
    - key_code = byte, key_ext = ext_p, key_release = brk_p.
    - key_valid pulses.
    - If (ext_p, byte) matches a key_held entry, that bit is set to !brk_p.
    - Both flags clear.
  - Unmapped codes still strobe key_valid but leave key_held untouched.
- Typematic repeat (repeated make codes): each repeat strobes key_valid with key_release = 0. The key_held bit stays 1.
- Extended and non-extended codes are distinct. E0-75 maps to Up; bare 75 (keypad 8) is unmapped.

## Timing
- Reset (rst = 0 at a posedge):
  - All outputs 0.
  - FSM to IDLE; counters, flags, shift register and synchronizers cleared.
  - Applies mid-frame: a partially received frame is lost, and reception restarts at the next start bit after rst returns to 1.
- key_valid and frame_err:
  - Assert exactly 2 cycles after the `fall` cycle of the stop bit (CHECK, then the output register).
  - Stay high for exactly 1 cycle.
  - Never assert together.
- key_code, key_ext and key_release update in the same cycle as key_valid and hold until the next key_valid.
- key_held updates in the same cycle as key_valid.
- Raw keyclk falling edge to `fall`: 3 cycles.
- Back-to-back frames need no gap beyond the PS/2 line timing; CHECK takes one cycle, far shorter than a PS/2 bit time (about 60 µs).
- A `fall` in the CHECK cycle cannot occur at legal PS/2 rates. If it does, it is ignored.

## Test plan
- Make A, then break A:
  - Stimulus: frames 1C, then F0 followed by 1C; valid parity, 15 kHz keyclk.
  - Response: key_valid (code 1C, ext 0, rel 0) and key_held[5] = 1.
  - Then key_valid (code 1C, rel 1) and key_held[5] = 0.
  - F0 produces no strobe.
- Extended arrow key:
  - Stimulus: E0 75, then E0 F0 75.
  - Response: code 75, ext 1; key_held[0] goes 1, then 0.
  - Bare 75: key_valid with ext 0, key_held unchanged.
- Parity error:
  - Stimulus: frame 5A with even parity.
  - Response: frame_err pulses 1 cycle, no key_valid, key_held[12] stays 0.
  - The following correct 5A sets key_held[12].
- Timeout:
  - Stimulus: start bit plus 4 data bits, then keyclk idle for TIMEOUT_CYCLES cycles, then a full frame 2D.
  - Response: no strobe from the partial frame; key_valid with code 2D, key_held[13] = 1.
- Reset mid-frame:
  - Stimulus: rst = 0 for 1 cycle after 6 bits of frame 3B, with key_held[4] previously set.
  - Response: all outputs 0 the next cycle; the remaining bits produce no strobe; the next full frame 3B decodes normally.
- Typematic repeat:
  - Stimulus: 1D three times.
  - Response: three key_valid strobes, each exactly 1 cycle wide and 2 cycles after the stop-bit `fall`; key_held[4] stays 1 throughout.
